deint_rd_addr: RTL and testbench

Read-side address generator for the deinterleaver RAM. Once the write side has filled a block for a given link length, this block produces the permuted read-address stream toward the downstream decoder. Reads are row-column: the block is written row-wise and read column-wise, offset by the per-link base address in the shared RAM. It uses a valid/request handshake so the consumer can stall at any beat.

---
 rtl/deint_rd_addr.sv | 119 +++++++++++
 tb/tb_deint_rd_addr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/deint_rd_addr.sv
// Read-side address generator for the deinterleaver RAM: emits the column-wise
// read-address stream of a row-wise written block, offset by the per-link base.
module deint_rd_addr #(
    parameter int ADDRESS   = 16,
    parameter int COLS_LOG2 = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [12:0]        m_len,
    input  logic               rd_req,
    output logic               rd_en,
    output logic [ADDRESS-1:0] rd_addr,
    output logic               rd_last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDRESS-1:0] ROW_STEP = ADDRESS'(1 << COLS_LOG2);

    logic [1:0]           state;
    logic [ADDRESS-1:0]   base;
    logic [8:0]           rows;
    logic [8:0]           row;
    logic [COLS_LOG2-1:0] col;

    logic                 len_ok;
    logic [ADDRESS-1:0]   len_base;
    logic [8:0]           len_rows;

    always_comb begin
        len_ok   = 1'b1;
        len_base = '0;
        len_rows = m_len[12:4];
        case (m_len)
            13'd288:  len_base = ADDRESS'(16'h0000);
            13'd672:  len_base = ADDRESS'(16'h0120);
            13'd1056: len_base = ADDRESS'(16'h03C0);
            13'd432:  len_base = ADDRESS'(16'h07E0);
            13'd1872: len_base = ADDRESS'(16'h0990);
            13'd5616: len_base = ADDRESS'(16'h10E0);
            default:  len_ok   = 1'b0;
        endcase
    end

    // rd_last is registered, so it is computed one beat ahead from the row
    // about to be presented; every supported block has at least 18 rows.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            base    <= '0;
            rows    <= '0;
            row     <= '0;
            col     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b0;
            rd_last <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            base  <= len_base;
                            rows  <= len_rows;
                            busy  <= 1'b1;
                            state <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    row     <= '0;
                    col     <= '0;
                    rd_addr <= base;
                    rd_en   <= 1'b1;
                    rd_last <= 1'b0;
                    state   <= RUN;
                end
                RUN: begin
                    if (rd_req) begin
                        if (rd_last) begin
                            rd_en   <= 1'b0;
                            rd_last <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else if (row == rows - 9'd1) begin
                            row     <= '0;
                            col     <= col + 1'b1;
                            rd_addr <= base + ADDRESS'(col) + ADDRESS'(1);
                            rd_last <= 1'b0;
                        end else begin
                            row     <= row + 9'd1;
                            rd_addr <= rd_addr + ROW_STEP;
                            rd_last <= (col == '1) && (row == rows - 9'd2);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deint_rd_addr.sv
// Scoreboard bench for deint_rd_addr: expected addresses are queued when a
// block is started and popped on every transferred beat.
module tb_deint_rd_addr;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [12:0] m_len;
    logic        rd_req;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic        rd_last;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    deint_rd_addr #(.ADDRESS(16), .COLS_LOG2(4)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .m_len(m_len), .rd_req(rd_req),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_last(rd_last), .busy(busy),
        .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] base_of(input logic [12:0] len);
        case (len)
            13'd288:  return 16'h0000;
            13'd672:  return 16'h0120;
            13'd1056: return 16'h03C0;
            13'd432:  return 16'h07E0;
            13'd1872: return 16'h0990;
            default:  return 16'h10E0;
        endcase
    endfunction

    // Drive start for one cycle and queue the full expected address stream.
    task automatic start_block(input logic [12:0] len);
        int rows;
        logic [15:0] b;
        rows = int'(len) / 16;
        b = base_of(len);
        exp_q.delete();
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < rows; r++)
                exp_q.push_back(b + 16'(r * 16 + c));
        start = 1'b1;
        m_len = len;
        @(posedge clk); #1;
        start = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_rd_en", rd_en, 0);
    endtask

    // toggle: rd_req alternates 1/0; inject_at: beat at which a stray start is
    // pulsed; reset_at: beat at which n_rst is pulsed (block abandoned).
    task automatic run_stream(input logic [12:0] len, input bit toggle,
                              input int inject_at, input int reset_at,
                              output int beats, output logic [15:0] last_addr);
        bit stalled = 0;
        bit finished = 0;
        logic [15:0] prev_addr = '0;
        logic prev_last = 0;
        int busy_cycles = 1;
        logic [15:0] e;
        beats = 0;
        last_addr = '0;
        for (int cyc = 0; cyc < 2 * int'(len) + 20; cyc++) begin
            if (busy) busy_cycles++;
            if (beats == reset_at && rd_en) begin
                n_rst = 1'b0;
                #1;
                chk("reset_outputs", {rd_en, rd_addr, rd_last, busy, done, err}, '0);
                n_rst = 1'b1;
                exp_q.delete();
                @(posedge clk); #1;
                chk("after_reset_idle", {rd_en, busy, done, err}, '0);
                return;
            end
            start = (beats == inject_at && rd_en) ? 1'b1 : 1'b0;
            if (start) m_len = 13'd1056;
            rd_req = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (stalled) begin
                chk("stall_hold_addr", rd_addr, prev_addr);
                chk("stall_hold_last", rd_last, prev_last);
            end
            if (rd_en && rd_req) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
                chk($sformatf("addr_beat%0d", beats), rd_addr, e);
                chk($sformatf("last_beat%0d", beats), rd_last, exp_q.size() == 0);
                beats++;
                last_addr = rd_addr;
                finished = rd_last;
            end
            stalled = rd_en && !rd_req;
            prev_addr = rd_addr;
            prev_last = rd_last;
            @(posedge clk); #1;
            start = 1'b0;
            if (finished) break;
        end
        rd_req = 1'b0;
        chk("finished_in_budget", finished, 1);
        chk("done_pulse", done, 1);
        chk("rd_en_after_last", rd_en, 0);
        chk("busy_in_done", busy, 1);
        if (!toggle) chk("start_to_idle_cycles", busy_cycles + 1, int'(len) + 3);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int beats;
        logic [15:0] la;
        n_rst = 1'b0;
        start = 1'b0;
        m_len = '0;
        rd_req = 1'b0;
        #12;
        chk("reset_values", {rd_en, rd_addr, rd_last, busy, done, err}, '0);
        n_rst = 1'b1;
        @(posedge clk); #1;

        start_block(13'd288);
        run_stream(13'd288, 0, -1, -1, beats, la);
        chk("beats_288", beats, 288);
        chk("final_288", la, 16'd287);

        start_block(13'd672);
        chk("first_672", exp_q[0], 16'h0120);
        run_stream(13'd672, 0, -1, -1, beats, la);
        chk("beats_672", beats, 672);
        chk("final_672", la, 16'h03BF);

        start_block(13'd5616);
        run_stream(13'd5616, 1, -1, -1, beats, la);
        chk("beats_5616", beats, 5616);
        chk("final_5616", la, 16'h26CF);

        start = 1'b1;
        m_len = 13'd100;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_rd_en", rd_en, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("err_cleared", {err, rd_en, busy, done}, '0);
        end

        start_block(13'd432);
        run_stream(13'd432, 0, 50, -1, beats, la);
        chk("beats_432", beats, 432);
        chk("final_432", la, 16'h07E0 + 16'd431);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_restart_after_inject", {rd_en, busy}, '0);
        end

        start_block(13'd1872);
        run_stream(13'd1872, 0, -1, 100, beats, la);
        chk("beats_before_reset", beats, 100);

        start_block(13'd288);
        run_stream(13'd288, 0, -1, -1, beats, la);
        chk("beats_288_after_reset", beats, 288);
        chk("final_288_after_reset", la, 16'd287);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
